// File: rtl/mod_named_block_seq.sv
// Multi-channel start/done sequencer: each channel walks a token through DEPTH
// stages, holds done until acked or aborted, and a shared counter tallies handshakes.
module mod_named_block_seq #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS-1:0]       i_start,
    input  logic [CHANNELS-1:0]       i_abort,
    input  logic [CHANNELS-1:0]       i_ack,
    output logic [CHANNELS-1:0]       o_busy,
    output logic [CHANNELS-1:0]       o_done,
    output logic [CHANNELS*CNT_W-1:0] o_stage,
    output logic [7:0]                o_done_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] STAGE_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(DEPTH);

    logic [CHANNELS-1:0] complete;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        state_t           state_reg;
        logic [CNT_W-1:0] stage_reg;
        logic             busy_reg;
        logic             done_reg;

        // busy/done are kept as registers updated alongside the state, so the
        // outputs never see a combinational path from the inputs.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state_reg <= ST_IDLE;
                stage_reg <= '0;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (i_start[gi] && !i_abort[gi]) begin
                            state_reg <= ST_RUN;
                            stage_reg <= STAGE_FIRST;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (i_abort[gi]) begin
                            state_reg <= ST_IDLE;
                            stage_reg <= '0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b0;
                        end else if (stage_reg < STAGE_LAST) begin
                            stage_reg <= stage_reg + STAGE_FIRST;
                        end else begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (i_abort[gi]) begin
                            state_reg <= ST_IDLE;
                            stage_reg <= '0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b0;
                        end else if (i_ack[gi] && i_start[gi]) begin
                            state_reg <= ST_RUN;
                            stage_reg <= STAGE_FIRST;
                            done_reg  <= 1'b0;
                        end else if (i_ack[gi]) begin
                            state_reg <= ST_IDLE;
                            stage_reg <= '0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        stage_reg <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end
                endcase
            end
        end

        // A handshake counts only when ack lands in DONE without an abort.
        assign complete[gi] = (state_reg == ST_DONE) && i_ack[gi] && !i_abort[gi];

        assign o_busy[gi]                   = busy_reg;
        assign o_done[gi]                   = done_reg;
        assign o_stage[gi*CNT_W +: CNT_W]   = stage_reg;
    end

    logic [7:0] count_reg;
    logic [7:0] count_next;
    logic [8:0] add_sum;
    logic [8:0] total;

    always_comb begin
        add_sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            add_sum = add_sum + 9'(complete[c]);
        end
        total      = {1'b0, count_reg} + add_sum;
        count_next = total[8] ? 8'hFF : total[7:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign o_done_count = count_reg;

endmodule

// File: doc/mod_named_block_seq.md
# mod_named_block_seq

Parametrised multi-channel start/done sequencer. Each channel accepts a start pulse, steps a token through DEPTH register stages, then holds a done flag until acknowledged. Per-channel abort is supported, and a shared counter records completed handshakes. It sits between a control issuer (start/abort) and a completion consumer (done/ack).

## Interface
Parameters:
- CHANNELS, default 2: number of independent channels, ≥1.
- DEPTH, default 4: stages per run, ≥1.
- CNT_W, default $clog2(DEPTH+1): stage index width. Derived; not overridden.

Ports:
- i_clk  input  1  sole clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  CHANNELS  per-channel start request, sampled on clock edge.
- i_abort  input  CHANNELS  per-channel abort; highest priority.
- i_ack  input  CHANNELS  per-channel acknowledge of o_done.
- o_busy  output  CHANNELS  channel not IDLE.
- o_done  output  CHANNELS  channel in DONE state.
- o_stage  output  CHANNELS*CNT_W  current stage index; channel c occupies bits [c*CNT_W +: CNT_W].
- o_done_count  output  8  completed done/ack handshakes, all channels, saturating.

## Operation
- Each channel has an independent FSM with states IDLE, RUN and DONE, plus a stage register.
- Reset (i_rst high, asynchronous): all FSMs go to IDLE, all stages to 0, o_done_count to 0. All outputs read 0 while reset is held and on release.
- IDLE (stage 0):
  - i_start=1 → RUN, stage=1.
  - Otherwise stay in IDLE.
- RUN:
  - i_abort=1 → IDLE, stage=0.
  - Else if stage<DEPTH, stage+1.
  - Else (stage==DEPTH) → DONE, stage held at DEPTH.
  - i_start is ignored.
- DONE (o_done=1, stage=DEPTH):
  - i_abort=1 → IDLE, stage=0; this is not counted as a completion.
  - Else i_ack=1 with i_start=1 → RUN, stage=1 (back-to-back run, no IDLE cycle); counted.
  - Else i_ack=1 → IDLE, stage=0; counted.
  - Else hold.
- i_ack outside DONE is ignored. i_abort in IDLE is ignored and blocks a same-cycle i_start (channel stays IDLE).
- Priority per channel: i_abort > i_ack > i_start.
- o_busy = (state≠IDLE). o_done = (state==DONE). Both are decoded from registered state only; there is no combinational input-to-output path.
- o_done_count:
  - Each cycle adds the number of channels completing a counted handshake; several channels may complete in the same cycle.
  - The sum is computed at 9 bits and clamped to 255.
  - Once at 255 it stays at 255 until reset.
- Channels share nothing except o_done_count.

## Timing
- Start sampled at edge E → o_busy=1 and stage=1 after E. stage=k after E+k-1. o_done=1 after E+DEPTH.
- Start-to-done latency is DEPTH cycles. For DEPTH=1: RUN for one cycle, DONE after E+1.
- Ack at edge A → o_done=0 after A, and o_done_count is updated after A (same edge).
- Back-to-back: ack+start at edge A → stage=1 after A, next o_done after A+DEPTH. Sustained throughput is one run per DEPTH+1 cycles per channel.
- Abort at edge B in RUN or DONE → IDLE after B. The earliest new start is sampled at B+1.
- Reset asserted mid-run: outputs clear immediately (asynchronous). No done pulse or count is emitted for the interrupted run.

## Test plan
- Reset check: assert i_rst mid-run on channel 0 (DEPTH=4, stage=2) → o_busy, o_done, o_stage and o_done_count read 0 immediately; after release the channel stays IDLE until a new start.
- Single run: CHANNELS=2, DEPTH=4, pulse i_start[0] at edge 0 → o_stage[0] reads 1,2,3,4 after edges 0..3; o_done[0]=1 after edge 4 and held 5 cycles until i_ack[0]; o_done_count=1 after the ack edge; channel 1 stays 0 throughout.
- Back-to-back: hold i_start[1]=1 continuously with i_ack[1]=1 continuously → o_done[1] asserts one cycle every 5; o_done_count increments by 1 every 5 cycles.
- Abort: i_abort[0] at stage 3 → IDLE next cycle, no done, count unchanged. Abort in DONE → o_done drops, count unchanged. Abort+start together in IDLE → stays IDLE.
- Simultaneous completion: both channels in DONE, acked on the same edge → o_done_count +2 in one cycle.
- Saturation: drive 300 completions → o_done_count reaches 255 and holds there. DEPTH=1 build: start → o_done after 2 edges.
